// File: rtl/boids_pkg.sv
// Shared constants, position types and FSM encoding for the boid frame writer.
package boids_pkg;
  localparam int MAX_BOIDS    = 4;
  localparam int VIDEO_WIDTH  = 640;
  localparam int VIDEO_HEIGHT = 480;
  localparam int ADDR_WIDTH   = 19;
  localparam int X_W          = 10;
  localparam int Y_W          = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWITCH = 2'd1,
    FETCH  = 2'd2,
    WRITE  = 2'd3
  } fw_state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } boid_pos_t;
endpackage

// File: rtl/pixel_addr_calc.sv
// Combinational pixel address (y*width + x) and visible-area test for one boid.
module pixel_addr_calc
  import boids_pkg::*;
#(
  parameter int VW = VIDEO_WIDTH,
  parameter int VH = VIDEO_HEIGHT,
  parameter int AW = ADDR_WIDTH
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic [AW-1:0]  addr,
  output logic           in_range
);
  localparam logic [X_W-1:0] X_LIM = X_W'(VW);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(VH);

  logic [AW-1:0] row_base;

  generate
    if (VW == 640) begin : g_shift640
      // 640 = 512 + 128, so the row base is two shifted copies of y
      assign row_base = (AW'(y) << 9) + (AW'(y) << 7);
    end else begin : g_generic
      assign row_base = AW'(y) * AW'(VW);
    end
  endgenerate

  assign addr     = row_base + AW'(x);
  assign in_range = (x < X_LIM) && (y < Y_LIM);
endmodule

// File: rtl/boid_frame_writer.sv
// Per frame: swap to a cleared buffer, then plot one pixel for each boid position.
module boid_frame_writer
  import boids_pkg::*;
#(
  parameter int MAX_BOIDS    = boids_pkg::MAX_BOIDS,
  parameter int VIDEO_WIDTH  = boids_pkg::VIDEO_WIDTH,
  parameter int VIDEO_HEIGHT = boids_pkg::VIDEO_HEIGHT,
  parameter int ADDR_WIDTH   = boids_pkg::ADDR_WIDTH,
  localparam int SW          = $clog2(MAX_BOIDS)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  screen_end,
  output logic [SW-1:0]         boid_sel,
  input  logic [X_W-1:0]        boid_x,
  input  logic [Y_W-1:0]        boid_y,
  output logic                  fb_switch,
  output logic                  fb_we,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  fb_data,
  output logic                  busy,
  output logic [7:0]            overrun_count
);
  fw_state_e       state, state_n;
  logic [SW-1:0]   idx;
  boid_pos_t       pos_q;
  logic [ADDR_WIDTH-1:0] calc_addr;
  logic            calc_in_range;
  logic            last;

  pixel_addr_calc #(
    .VW (VIDEO_WIDTH),
    .VH (VIDEO_HEIGHT),
    .AW (ADDR_WIDTH)
  ) u_addr (
    .x        (pos_q.x),
    .y        (pos_q.y),
    .addr     (calc_addr),
    .in_range (calc_in_range)
  );

  assign last     = (idx == SW'(MAX_BOIDS - 1));
  assign busy     = (state != IDLE);
  assign boid_sel = idx;
  assign fb_data  = 1'b1;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (screen_end) state_n = SWITCH;
      SWITCH:  state_n = FETCH;
      FETCH:   state_n = WRITE;
      WRITE:   state_n = last ? IDLE : FETCH;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      idx           <= '0;
      pos_q         <= '0;
      fb_switch     <= 1'b0;
      fb_we         <= 1'b0;
      fb_addr       <= '0;
      overrun_count <= '0;
    end else begin
      state     <= state_n;
      fb_switch <= (state == IDLE) && screen_end;
      fb_we     <= (state == WRITE) && calc_in_range;
      // Off-screen boids leave the previous address in place
      if (state == WRITE && calc_in_range) fb_addr <= calc_addr;
      if (state == SWITCH)             idx <= '0;
      else if (state == WRITE && !last) idx <= idx + SW'(1);
      if (state == FETCH) pos_q <= '{x: boid_x, y: boid_y};
      // A frame end during a scan is dropped; that includes the final WRITE cycle
      if (busy && screen_end && overrun_count != 8'hFF)
        overrun_count <= overrun_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_boid_frame_writer.sv
// Directed bench: scan-offset model checked every cycle plus literal expectations per scenario.
`timescale 1ns/1ps
module tb_boid_frame_writer;
  localparam int MB = 4;
  localparam int VW = 640;
  localparam int VH = 480;

  logic clock = 1'b0;
  logic resetn = 1'b1;
  logic screen_end = 1'b0;
  logic screen_end8 = 1'b0;

  logic [1:0]  boid_sel;
  logic [9:0]  boid_x;
  logic [8:0]  boid_y;
  logic        fb_switch, fb_we, fb_data, busy;
  logic [18:0] fb_addr;
  logic [7:0]  overrun_count;

  logic [2:0]  boid_sel8;
  logic [9:0]  boid_x8;
  logic [8:0]  boid_y8;
  logic        fb_switch8, fb_we8, fb_data8, busy8;
  logic [18:0] fb_addr8;
  logic [7:0]  overrun_count8;

  logic [9:0] pos_x [8];
  logic [8:0] pos_y [8];

  assign boid_x  = pos_x[boid_sel];
  assign boid_y  = pos_y[boid_sel];
  assign boid_x8 = pos_x[boid_sel8];
  assign boid_y8 = pos_y[boid_sel8];

  boid_frame_writer dut (
    .clock(clock), .resetn(resetn), .screen_end(screen_end), .boid_sel(boid_sel),
    .boid_x(boid_x), .boid_y(boid_y), .fb_switch(fb_switch), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy), .overrun_count(overrun_count)
  );

  boid_frame_writer #(.MAX_BOIDS(8)) dut8 (
    .clock(clock), .resetn(resetn), .screen_end(screen_end8), .boid_sel(boid_sel8),
    .boid_x(boid_x8), .boid_y(boid_y8), .fb_switch(fb_switch8), .fb_we(fb_we8),
    .fb_addr(fb_addr8), .fb_data(fb_data8), .busy(busy8), .overrun_count(overrun_count8)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_off counts cycles since a frame end was accepted (1 = swap cycle).
  // Boid k is fetched at offset 2+2k and its pixel write shows at offset 4+2k.
  int m_off = -1;
  int m_prev, m_slot, m_k;
  bit m_busy = 0, m_sw = 0, m_we = 0, m_sel_chk = 0;
  int m_addr = 0, m_ovr = 0, m_sel = 0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_off = -1; m_busy = 0; m_sw = 0; m_we = 0; m_addr = 0; m_ovr = 0; m_sel_chk = 0;
    end else begin
      m_prev = m_off;
      m_slot = (m_prev >= 1) ? m_prev + 1 : -1;
      if (screen_end && m_busy) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
      if (screen_end && !m_busy)                 m_off = 1;
      else if (m_prev >= 1 && m_prev < 2*MB + 1) m_off = m_prev + 1;
      else                                       m_off = -1;
      m_busy = (m_off >= 1) && (m_off <= 2*MB + 1);
      m_sw   = (m_off == 1);
      m_we   = 0;
      if (m_slot >= 4 && m_slot <= 2*MB + 2 && (m_slot % 2) == 0) begin
        m_k = (m_slot - 4) / 2;
        if (int'(pos_x[m_k]) < VW && int'(pos_y[m_k]) < VH) begin
          m_we   = 1;
          m_addr = int'(pos_y[m_k]) * VW + int'(pos_x[m_k]);
        end
      end
      m_sel_chk = (m_off >= 2) && (m_off <= 2*MB) && ((m_off % 2) == 0);
      m_sel     = (m_off - 2) / 2;
    end
  end

  bit checking = 0;
  int obs[$];
  int busy_cnt = 0;
  int we_cnt = 0;
  int busy8_cnt = 0;
  int seq8[$];

  always @(negedge clock) begin
    if (checking) begin
      chk("busy", int'(busy), int'(m_busy));
      chk("fb_switch", int'(fb_switch), int'(m_sw));
      chk("fb_we", int'(fb_we), int'(m_we));
      chk("fb_addr", int'(fb_addr), m_addr);
      chk("fb_data", int'(fb_data), 1);
      chk("overrun_count", int'(overrun_count), m_ovr);
      if (m_sel_chk) chk("boid_sel", int'(boid_sel), m_sel);
      if (fb_we) begin obs.push_back(int'(fb_addr)); we_cnt++; end
      if (busy) busy_cnt++;
      if (busy8) begin
        busy8_cnt++;
        if (seq8.size() == 0 || seq8[$] != int'(boid_sel8)) seq8.push_back(int'(boid_sel8));
      end
    end
  end

  task automatic pulse();
    @(posedge clock); #2 screen_end = 1'b1;
    @(posedge clock); #2 screen_end = 1'b0;
  endtask

  task automatic set_pos(input int k, input int x, input int y);
    pos_x[k] = 10'(x);
    pos_y[k] = 9'(y);
  endtask

  task automatic clear_obs();
    obs.delete(); busy_cnt = 0; we_cnt = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_fb_switch"}, int'(fb_switch), 0);
    chk({tag, "_fb_we"}, int'(fb_we), 0);
    chk({tag, "_fb_addr"}, int'(fb_addr), 0);
    chk({tag, "_overrun"}, int'(overrun_count), 0);
    chk({tag, "_boid_sel"}, int'(boid_sel), 0);
  endtask

  int n;

  initial begin
    for (int i = 0; i < 8; i++) set_pos(i, 20*i, 10*i);
    set_pos(0, 0, 0); set_pos(1, 10, 10); set_pos(2, 639, 479); set_pos(3, 100, 200);

    #1 resetn = 1'b0;
    #1 chk_reset_state("reset");
    checking = 1;
    repeat (2) @(posedge clock);
    #2 resetn = 1'b1;
    repeat (2) @(posedge clock);

    // Four in-range boids
    clear_obs(); pulse(); repeat (14) @(posedge clock);
    chk("s1_writes", obs.size(), 4);
    if (obs.size() == 4) begin
      chk("s1_addr0", obs[0], 0);
      chk("s1_addr1", obs[1], 6410);
      chk("s1_addr2", obs[2], 307199);
      chk("s1_addr3", obs[3], 128100);
    end
    chk("s1_busy_len", busy_cnt, 9);

    // Off-screen boids skipped
    set_pos(1, 640, 5); set_pos(2, 5, 480); set_pos(3, 639, 479);
    clear_obs(); pulse(); repeat (14) @(posedge clock);
    chk("s2_writes", obs.size(), 2);
    if (obs.size() == 2) begin
      chk("s2_addr0", obs[0], 0);
      chk("s2_addr3", obs[1], 307199);
    end
    chk("s2_busy_len", busy_cnt, 9);

    // Frame end arriving mid-scan
    set_pos(1, 10, 10); set_pos(2, 639, 479); set_pos(3, 100, 200);
    clear_obs(); pulse();
    @(posedge clock); @(posedge clock); #2 screen_end = 1'b1;
    @(posedge clock); #2 screen_end = 1'b0;
    repeat (14) @(posedge clock);
    chk("s3_overrun", int'(overrun_count), 1);
    chk("s3_writes", obs.size(), 4);
    chk("s3_busy_len", busy_cnt, 9);

    // Saturating overrun counter
    n = 0;
    while (n < 300) begin
      @(posedge clock); #2 screen_end = 1'b1;
      if (m_busy) n++;
    end
    @(posedge clock); #2 screen_end = 1'b0;
    repeat (12) @(posedge clock);
    chk("s4_overrun_sat", int'(overrun_count), 255);

    // Reset during FETCH of boid 2
    pulse();
    repeat (5) @(posedge clock);
    #3 resetn = 1'b0;
    #1 chk_reset_state("s5_async");
    @(posedge clock); #2 resetn = 1'b1;
    clear_obs(); repeat (15) @(posedge clock);
    chk("s5_no_we_after_reset", we_cnt, 0);
    chk("s5_idle_after_reset", busy_cnt, 0);
    clear_obs(); pulse(); repeat (14) @(posedge clock);
    chk("s5_recover_writes", obs.size(), 4);
    if (obs.size() == 4) chk("s5_recover_addr3", obs[3], 128100);

    // Eight-boid build
    busy8_cnt = 0; seq8.delete();
    @(posedge clock); #2 screen_end8 = 1'b1;
    @(posedge clock); #2 screen_end8 = 1'b0;
    repeat (22) @(posedge clock);
    chk("s6_busy8_len", busy8_cnt, 17);
    chk("s6_sel8_count", seq8.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < seq8.size()) chk("s6_sel8_seq", seq8[i], i);
    chk("s6_fb_addr8_last", int'(fb_addr8), 70*VW + 140);

    @(negedge clock);
    checking = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
